// File: rtl/deco_two_four_tx_pkg.sv
// Shared types for the 2-to-4 pulse transmitter: FSM state encoding and the
// code-to-one-hot mapping used for a_out.
package deco_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } tx_state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] code);
      return 4'b0001 << code;
   endfunction

endpackage

// File: rtl/deco_two_four_tx_fifo_codes.sv
// Small synchronous FIFO holding pending codes. Pointers wrap mod DEPTH, and
// occupancy is tracked in its own counter so full and empty stay distinct.
module fifo_codes #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // A full FIFO refuses the push even when the same edge pops.
   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/deco_two_four_tx.sv
// Replays buffered 2-bit codes as timed one-hot pulses on a_out, with an
// optional all-zero gap between consecutive pulses.
module deco_two_four_tx
   import deco_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [1:0]              in_code,
   output logic                    in_ready,
   output logic [3:0]              a_out,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES)
                            ? ((PULSE_CYCLES > 2) ? PULSE_CYCLES : 2)
                            : ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
   localparam int CW = $clog2(CNT_MAX);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [3:0]    a_nxt;
   logic          pop;
   logic [1:0]    head;
   logic          full;
   logic          empty;

   fifo_codes #(.DEPTH(DEPTH), .W(2)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid),
      .push_data (in_code),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign in_ready = ~full;
   assign busy     = (state != IDLE) | ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         a_out <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         a_out <= a_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      a_nxt     = a_out;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               a_nxt     = onehot4(head);
               cnt_nxt   = PULSE_LOAD;
               state_nxt = PULSE;
            end
         end
         PULSE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else if (GAP_CYCLES > 0) begin
               a_nxt     = 4'b0000;
               cnt_nxt   = GAP_LOAD;
               state_nxt = GAP;
            end else if (!empty) begin
               // Zero-gap mode: chain straight into the next pulse.
               pop     = 1'b1;
               a_nxt   = onehot4(head);
               cnt_nxt = PULSE_LOAD;
            end else begin
               a_nxt     = 4'b0000;
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else if (!empty) begin
               pop       = 1'b1;
               a_nxt     = onehot4(head);
               cnt_nxt   = PULSE_LOAD;
               state_nxt = PULSE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            a_nxt     = 4'b0000;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
